// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with a pending-write scoreboard.
// Storage is cleared by a one-entry-per-cycle sweep after reset or on clr_req,
// so the array itself carries no reset and can map onto RAM-style storage.
//
// Handshake: there is no valid/ready pairing on the write or issue strobes.
// "ready" is a status flag. While it is 0 (sweep running), wr_en and issue_en
// are dropped, and every read port returns data 0 and busy 0. While it is 1,
// every strobe presented at a rising edge takes effect at that edge.
module regfile_mp_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              ready,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_rd,
  output logic [NRD-1:0]    rd_busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // One extra bit so NREGS itself is representable when NREGS == 2**AW.
  localparam logic [AW:0]   NREGS_W  = NREGS[AW:0];
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic          ZERO_ON  = (ZERO_REG != 0);

  state_t            state;
  logic [AW-1:0]     clr_idx;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;

  logic              wr_legal;
  logic              issue_legal;
  logic              we_eff;
  logic              issue_eff;

  // An index is usable if it is in range and is not the hardwired-zero register.
  assign wr_legal    = ({1'b0, wr_addr} < NREGS_W) && !(ZERO_ON && (wr_addr == '0));
  assign issue_legal = ({1'b0, issue_rd} < NREGS_W) && !(ZERO_ON && (issue_rd == '0));
  assign we_eff      = ready && wr_en && wr_legal;
  assign issue_eff   = ready && issue_en && issue_legal;

  // Control FSM: clear sweep, then run; clr_req restarts the sweep from entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_req) begin
            clr_idx <= '0;
          end else if (clr_idx == LAST_IDX) begin
            clr_idx <= '0;
            state   <= ST_RUN;
            ready   <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            clr_idx <= '0;
            state   <= ST_CLEAR;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_idx <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage: the sweep zeroes one entry per cycle, otherwise the single write port updates.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      regs[clr_idx] <= '0;
    end else if (we_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: issue sets busy, a write clears it, and set wins when both hit one register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (!ready || clr_req) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (issue_eff && (issue_rd == AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (we_eff && (wr_addr == AW'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: zero-latency, with the same-cycle write forwarded and its busy bit masked.
  always_comb begin
    logic [AW-1:0] a;
    logic          legal;
    logic          hit;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    legal   = 1'b0;
    hit     = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      a     = rd_addr[k*AW +: AW];
      legal = ({1'b0, a} < NREGS_W) && !(ZERO_ON && (a == '0));
      hit   = we_eff && (wr_addr == a);
      if (ready && legal) begin
        rd_data[k*XLEN +: XLEN] = hit ? wr_data : regs[a];
        rd_busy[k]              = busy[a] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: a vector table for run-mode behaviour,
// plus hand sequences for reset, clear sweeps and asynchronous reset.
module tb_regfile_mp_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clr_req;
  logic                 ready;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic                 issue_en;
  logic [AW-1:0]        issue_rd;
  logic [NRD-1:0]       rd_busy;

  regfile_mp_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .rd_busy(rd_busy)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          issue_en;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [31:0]   ed0;
    logic [31:0]   ed1;
    logic [1:0]    eb;
  } vec_t;

  vec_t vt [15];

  // Scoreboard comparison
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
    rd_addr  = '0;
  endtask

  // Called just after the edge that starts a sweep: ready must stay 0 for 31 edges
  // and rise on the 32nd, with writes/issues ignored and reads forced to 0 meanwhile.
  task automatic expect_sweep(input string tag);
    for (int i = 1; i <= NREGS; i++) begin
      wr_en    = 1'b1;
      wr_addr  = AW'($urandom_range(1, NREGS - 1));
      wr_data  = $urandom;
      issue_en = 1'b1;
      issue_rd = AW'($urandom_range(1, NREGS - 1));
      rd_addr  = {wr_addr, issue_rd};
      step();
      check($sformatf("%s ready edge %0d", tag, i), 64'(ready), 64'(i == NREGS));
      if (i < NREGS) begin
        check($sformatf("%s rd_data edge %0d", tag, i), rd_data, 64'h0);
        check($sformatf("%s rd_busy edge %0d", tag, i), 64'(rd_busy), 64'h0);
      end
    end
    idle_inputs();
  endtask

  // Every register must read 0 and non-busy on both ports.
  task automatic check_all_zero(input string tag);
    for (int r = 0; r < NREGS; r++) begin
      rd_addr = {AW'(NREGS - 1 - r), AW'(r)};
      #1;
      check($sformatf("%s data x%0d", tag, r), rd_data, 64'h0);
      check($sformatf("%s busy x%0d", tag, r), 64'(rd_busy), 64'h0);
    end
  endtask

  initial begin
    idle_inputs();

    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vt[2]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
    vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h0,        32'h0,        2'b11};
    vt[7]  = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0, 5'd7,  5'd5,  32'h00000055, 32'hDEADBEEF, 2'b00};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h00000055, 32'h00000055, 2'b00};
    vt[9]  = '{1'b1, 5'd7,  32'h00000066, 1'b1, 5'd7, 5'd7,  5'd3,  32'h00000066, 32'h0,        2'b00};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd7,  32'h00000066, 32'h00000066, 2'b11};
    vt[11] = '{1'b1, 5'd3,  32'h0000AAAA, 1'b1, 5'd3, 5'd3,  5'd7,  32'h0000AAAA, 32'h00000066, 2'b10};
    vt[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd7,  32'h0000AAAA, 32'h00000066, 2'b11};
    vt[13] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        2'b00};
    vt[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd3,  32'hFFFFFFFF, 32'h0000AAAA, 2'b10};

    // T1: reset held 3 cycles, then the power-on sweep
    reset = 1'b1;
    #1;
    check("reset ready", 64'(ready), 64'h0);
    check("reset rd_data", rd_data, 64'h0);
    check("reset rd_busy", 64'(rd_busy), 64'h0);
    step(); step(); step();
    reset = 1'b0;
    expect_sweep("t1");
    check_all_zero("t1");

    // T2-T4: run-mode vector table, checked before each edge
    for (int i = 0; i < 15; i++) begin
      wr_en    = vt[i].wr_en;
      wr_addr  = vt[i].wr_addr;
      wr_data  = vt[i].wr_data;
      issue_en = vt[i].issue_en;
      issue_rd = vt[i].issue_rd;
      rd_addr  = {vt[i].ra1, vt[i].ra0};
      #2;
      check($sformatf("vec%0d data0", i), 64'(rd_data[31:0]), 64'(vt[i].ed0));
      check($sformatf("vec%0d data1", i), 64'(rd_data[63:32]), 64'(vt[i].ed1));
      check($sformatf("vec%0d busy", i), 64'(rd_busy), 64'(vt[i].eb));
      step();
    end
    idle_inputs();

    // T5: clear request with loaded registers and x3/x7 busy
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("t5 ready after clr", 64'(ready), 64'h0);
    expect_sweep("t5");
    check_all_zero("t5");

    // clr_req during a sweep restarts it from entry 0
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h99;
    step();
    idle_inputs();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    expect_sweep("restart");
    check_all_zero("restart");

    // T6: asynchronous reset mid-sweep (clr_idx = 10)
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check("t6 ready async mid-sweep", 64'(ready), 64'h0);
    step(); step();
    reset = 1'b0;
    expect_sweep("t6");

    // Asynchronous reset from run mode drops ready and reads without a clock edge
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    step();
    idle_inputs();
    rd_addr = {5'd9, 5'd9};
    #2;
    check("t6 x9 before reset", rd_data, {32'h77, 32'h77});
    reset = 1'b1;
    #1;
    check("t6 ready async run", 64'(ready), 64'h0);
    check("t6 rd_data async run", rd_data, 64'h0);
    step();
    reset = 1'b0;
    expect_sweep("t6b");
    check_all_zero("t6b");

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
